seq_mult_hs: RTL and testbench

Parametrised serial shift-add multiplier: one multiplier bit per clock, minimum-area datapath.
Supports a signed or unsigned mode per transaction, selected at issue time.
Uses a valid/ready handshake on both input and output, and has a synchronous abort.
Sits in the multiplier library as the area-optimised option for non-throughput-critical datapaths.

---
 rtl/seq_mult_pkg.sv | 39 +++
 rtl/seq_mult_dp.sv | 82 ++++++++
 rtl/seq_mult_hs.sv | 140 ++++++++++++++
 tb/tb_seq_mult_hs.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the serial shift-add multiplier.
//   state_e   : controller states
//   cnt_width : width of the CALC iteration counter for a given WIDTH_A
//   abs_val   : magnitude of a W-bit operand, two's-complement only when requested
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operands are carried through abs_val in a 64-bit container.
  localparam int unsigned MAX_OP_W = 63;

  // Counter must be able to represent WIDTH_A iterations.
  function automatic int unsigned cnt_width(input int unsigned width_a);
    return $clog2(width_a + 32'd1);
  endfunction

  // Magnitude of the low 'width' bits of value. The most negative value maps to
  // 2^(width-1), which still fits in 'width' unsigned bits.
  function automatic logic [63:0] abs_val(input logic [63:0]   value,
                                          input int unsigned   width,
                                          input logic          signed_en);
    logic [63:0] mask;
    logic [63:0] neg;
    logic        msb;
    mask = (64'd1 << width) - 64'd1;
    neg  = (~value + 64'd1) & mask;
    msb  = value[6'(width - 32'd1)];
    if (signed_en && msb) begin
      return neg;
    end
    return value & mask;
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Datapath of the serial multiplier: product register P, conditional add/shift
// and the final conditional negate into the registered result.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous abort, clears the accumulator (result is kept)
//   load       : start a transaction with mag_a/mag_b/sign_in
//   step       : one shift-add iteration
//   fix        : write the signed/unsigned product into yout
//   mag_a      : multiplier magnitude, mag_b : multiplicand magnitude
//   sign_in    : result must be negated
//   yout       : registered product
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH_A = 16,
  parameter int unsigned WIDTH_B = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       load,
  input  logic                       step,
  input  logic                       fix,
  input  logic [WIDTH_A-1:0]         mag_a,
  input  logic [WIDTH_B-1:0]         mag_b,
  input  logic                       sign_in,
  output logic [WIDTH_A+WIDTH_B-1:0] yout
);

  localparam int unsigned P_W  = WIDTH_A + WIDTH_B + 1;
  localparam int unsigned Y_W  = WIDTH_A + WIDTH_B;
  localparam int unsigned UP_W = WIDTH_B + 1;

  logic [P_W-1:0]     r_p;
  logic [WIDTH_B-1:0] r_mag_b;
  logic               r_sign;
  logic [Y_W-1:0]     r_yout;

  logic [UP_W-1:0]    w_sum;
  logic [UP_W-1:0]    w_upper;
  logic [P_W-1:0]     w_p_nxt;
  logic [Y_W-1:0]     w_y_mag;
  logic [Y_W-1:0]     w_y;

  // Upper WIDTH_B+1 bits never overflow: partial sum < 2^(WIDTH_B+1).
  assign w_sum   = r_p[P_W-1:WIDTH_A] + {1'b0, r_mag_b};
  assign w_upper = r_p[0] ? w_sum : r_p[P_W-1:WIDTH_A];
  assign w_p_nxt = {1'b0, w_upper, r_p[WIDTH_A-1:1]};

  assign w_y_mag = r_p[Y_W-1:0];
  assign w_y     = r_sign ? (~w_y_mag + Y_W'(1)) : w_y_mag;

  // Accumulator and per-transaction operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_mag_b <= '0;
      r_sign  <= 1'b0;
    end else if (clr) begin
      r_p     <= '0;
      r_mag_b <= '0;
      r_sign  <= 1'b0;
    end else if (load) begin
      r_p     <= {UP_W'(0), mag_a};
      r_mag_b <= mag_b;
      r_sign  <= sign_in;
    end else if (step) begin
      r_p     <= w_p_nxt;
    end
  end

  // Result register survives clr and handoff; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_yout <= '0;
    end else if (fix && !clr) begin
      r_yout <= w_y;
    end
  end

  assign yout = r_yout;

endmodule

// File: rtl/seq_mult_hs.sv
// Area-optimised serial shift-add multiplier with valid/ready handshakes.
// One multiplier bit per clock; signed or unsigned selected per transaction.
//   clk, rst_n          : clock, async active-low reset
//   clr                 : synchronous abort back to IDLE
//   in_valid/in_ready   : operand handshake (in_ready only in IDLE)
//   in_signed, ain, bin : mode and operands, sampled at accept
//   out_valid/out_ready : result handshake
//   yout                : registered product
//   busy                : high in CALC or FIX
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH_A = 16,
  parameter int unsigned WIDTH_B = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_signed,
  input  logic [WIDTH_A-1:0]         ain,
  input  logic [WIDTH_B-1:0]         bin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] yout,
  output logic                       busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH_A);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic               w_accept;
  logic               w_last;
  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic [WIDTH_A-1:0] w_mag_a;
  logic [WIDTH_B-1:0] w_mag_b;
  logic               w_sign;

  // clr wins over a same-cycle accept.
  assign w_accept = in_valid && r_in_ready && !clr;
  assign w_last   = (r_cnt == CNT_W'(WIDTH_A - 32'd1));

  assign w_mag_a = WIDTH_A'(abs_val(64'(ain), WIDTH_A, in_signed));
  assign w_mag_b = WIDTH_B'(abs_val(64'(bin), WIDTH_B, in_signed));
  assign w_sign  = in_signed & (ain[WIDTH_A-1] ^ bin[WIDTH_B-1]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_CALC;
      ST_CALC: if (w_last)   w_state_nxt = ST_FIX;
      ST_FIX:                w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
    if (clr) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Datapath strobes.
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    if (!clr) begin
      unique case (r_state)
        ST_IDLE: w_load = w_accept;
        ST_CALC: w_step = 1'b1;
        ST_FIX:  w_fix  = 1'b1;
        default: ;
      endcase
    end
  end

  // Handshake/status outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt == ST_CALC) || (w_state_nxt == ST_FIX);
    end
  end

  // Iteration counter: cleared at accept, counts CALC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || w_load) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  seq_mult_dp #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .load    (w_load),
    .step    (w_step),
    .fix     (w_fix),
    .mag_a   (w_mag_a),
    .mag_b   (w_mag_b),
    .sign_in (w_sign),
    .yout    (yout)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed testbench for seq_mult_hs: a 16x16 instance and an 8x12 instance.
module tb_seq_mult_hs;

  logic        clk;
  logic        rst_n;

  // 16x16 instance
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [15:0] ain;
  logic [15:0] bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] yout;
  logic        busy;

  // 8x12 instance
  logic        clr8;
  logic        in_valid8;
  logic        in_ready8;
  logic        in_signed8;
  logic [7:0]  ain8;
  logic [11:0] bin8;
  logic        out_valid8;
  logic        out_ready8;
  logic [19:0] yout8;
  logic        busy8;

  int n_cmp;
  int n_mis;

  seq_mult_hs #(.WIDTH_A(16), .WIDTH_B(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .ain       (ain),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .yout      (yout),
    .busy      (busy)
  );

  seq_mult_hs #(.WIDTH_A(8), .WIDTH_B(12)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_signed (in_signed8),
    .ain       (ain8),
    .bin       (bin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .yout      (yout8),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- 16x16 helpers ----------------
  task automatic issue16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check({tag, " in_ready before issue"}, 64'(in_ready), 64'd1);
    ain       = a;
    bin       = b;
    in_signed = s;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    check({tag, " busy after accept"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_valid16(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] exp);
    int lat;
    issue16(tag, a, b, s);
    wait_valid16(lat);
    check({tag, " latency"}, 64'(lat), 64'd17);
    check({tag, " yout"}, 64'(yout), 64'(exp));
    tick();
    check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready back"}, 64'(in_ready), 64'd1);
  endtask

  // ---------------- 8x12 helpers ----------------
  task automatic run8(input string tag, input logic [7:0] a, input logic [11:0] b,
                      input logic s, input logic [19:0] exp);
    int k;
    int lat;
    k = 0;
    while (!in_ready8 && k < 50) begin
      tick();
      k++;
    end
    check({tag, " in_ready before issue"}, 64'(in_ready8), 64'd1);
    ain8       = a;
    bin8       = b;
    in_signed8 = s;
    in_valid8  = 1'b1;
    tick();
    in_valid8  = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid8 && lat < 40);
    check({tag, " latency"}, 64'(lat), 64'd9);
    check({tag, " yout"}, 64'(yout8), 64'(exp));
    tick();
    check({tag, " in_ready back"}, 64'(in_ready8), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    n_cmp      = 0;
    n_mis      = 0;
    rst_n      = 1'b0;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_signed  = 1'b0;
    ain        = '0;
    bin        = '0;
    out_ready  = 1'b1;
    clr8       = 1'b0;
    in_valid8  = 1'b0;
    in_signed8 = 1'b0;
    ain8       = '0;
    bin8       = '0;
    out_ready8 = 1'b1;

    // Reset state
    #12;
    check("reset in_ready",  64'(in_ready),  64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy",      64'(busy),      64'd0);
    check("reset yout",      64'(yout),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic unsigned and signed products
    run16("u 4*3",          16'h0004, 16'h0003, 1'b0, 32'h0000_000C);
    run16("s -3*5",         16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1);
    run16("u 0xFFFD*5",     16'hFFFD, 16'h0005, 1'b0, 32'h0004_FFF1);
    run16("s min*min",      16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    run16("u max*max",      16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    run16("s -1*-1",        16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
    run16("s 0*-7",         16'h0000, 16'hFFF9, 1'b1, 32'h0000_0000);

    // Backpressure: result held, new operands ignored
    out_ready = 1'b0;
    begin
      int lat;
      issue16("bp", 16'h1234, 16'h0010, 1'b0);
      wait_valid16(lat);
      check("bp latency", 64'(lat), 64'd17);
      check("bp yout", 64'(yout), 64'h0001_2340);
      ain      = 16'hAAAA;
      bin      = 16'h5555;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        check("bp yout stable",  64'(yout),      64'h0001_2340);
        check("bp out_valid",    64'(out_valid), 64'd1);
        check("bp in_ready low", 64'(in_ready),  64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp released out_valid", 64'(out_valid), 64'd0);
      check("bp released in_ready",  64'(in_ready),  64'd1);
      check("bp yout kept",          64'(yout),      64'h0001_2340);
    end

    // Abort on the 8th CALC cycle
    issue16("clr", 16'h00FF, 16'h00FF, 1'b0);
    repeat (7) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr busy",      64'(busy),      64'd0);
    check("clr in_ready",  64'(in_ready),  64'd1);
    check("clr out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("clr no out_valid", 64'(seen), 64'd0);
    check("clr yout kept", 64'(yout), 64'h0001_2340);
    run16("after clr 7*9", 16'h0007, 16'h0009, 1'b0, 32'd63);

    // clr together with in_valid in IDLE: no accept
    ain      = 16'h0003;
    bin      = 16'h0003;
    in_valid = 1'b1;
    clr      = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr+valid in_ready", 64'(in_ready), 64'd1);
    check("clr+valid busy",     64'(busy),     64'd0);
    repeat (20) tick();
    check("clr+valid no result", 64'(out_valid), 64'd0);
    check("clr+valid yout",      64'(yout),      64'd63);

    // Asynchronous reset mid-CALC
    issue16("rst", 16'h0100, 16'h0100, 1'b0);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst in_ready",  64'(in_ready),  64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy",      64'(busy),      64'd0);
    check("rst yout",      64'(yout),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run16("after rst -3*-3", 16'hFFFD, 16'hFFFD, 1'b1, 32'd9);

    // 8x12 instance
    run8("8x12 u max*max",   8'hFF, 12'hFFF, 1'b0, 20'hFEF01);
    run8("8x12 s min*min",   8'h80, 12'h800, 1'b1, 20'h40000);
    run8("8x12 s min*max",   8'h80, 12'h7FF, 1'b1, 20'hC0080);
    run8("8x12 s 5*-3",      8'h05, 12'hFFD, 1'b1, 20'hFFFF1);
    run8("8x12 u 5*0xFFD",   8'h05, 12'hFFD, 1'b0, 20'h04FF1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
